pb_debouncer_array: RTL
=======================

PB_DEBOUNCER_ARRAY -- requirements
Module: pb_debouncer_array

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent push-button channels (1..32).
REQ-002 SHALL have parameter STABLE_CYCLES, default 50000, meaning consecutive stable clock cycles required to accept a level (1 ms at 50 MHz); legal range >= 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops per channel (>= 2).
REQ-004 SHALL have parameter LONG_CYCLES, default 0, meaning cycles of accepted press before pb_long pulses; 0 disables long-press detection.
REQ-005 SHALL have parameter ACTIVE_LOW, default 0, meaning 1 inverts raw pb before synchronisation.
REQ-006 SHALL have port clock  input  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port PB  input  N_CH  raw asynchronous button levels.
REQ-009 SHALL have port PB_state  output  N_CH  debounced level, 1 = pressed.
REQ-010 SHALL have port pb_down  output  N_CH  one-cycle pulse on accepted press.
REQ-011 SHALL have port pb_up  output  N_CH  one-cycle pulse on accepted release.
REQ-012 SHALL have port pb_long  output  N_CH  one-cycle pulse when press held LONG_CYCLES.

Function
REQ-013 SHALL pass each PB bit, after optional inversion, through SYNC_STAGES flops; only the last stage feeds the debounce logic.
REQ-014 SHALL keep per channel a stability counter of width $clog2(STABLE_CYCLES) that increments each cycle the synchronised level differs from PB_state, and clears to 0 any cycle they match.
REQ-015 SHALL, on the STABLE_CYCLES-th consecutive mismatch cycle, toggle PB_state, clear the counter, and assert pb_down (new state 1) or pb_up (new state 0) in that same cycle.
REQ-016 SHALL give latency from a clean PB step to the PB_state change of exactly SYNC_STAGES + STABLE_CYCLES rising edges.
REQ-017 SHALL restart the count from 0 on any bounce; a mismatch lasting STABLE_CYCLES-1 cycles SHALL produce no output change.
REQ-018 SHALL, when LONG_CYCLES > 0, count cycles while PB_state = 1, pulse pb_long exactly once when the count reaches LONG_CYCLES, then saturate with no repeat; the count SHALL clear when PB_state = 0.
REQ-019 SHALL hold pb_long at 0 permanently when LONG_CYCLES = 0.
REQ-020 SHALL operate all channels independently; simultaneous events on several channels SHALL produce their pulses in the same cycle.
REQ-021 SHALL never assert pb_down and pb_up on the same channel in the same cycle; all outputs SHALL be registered.

Reset
REQ-022 SHALL, while reset = 1 at a rising edge, clear synchroniser flops, counters, PB_state, pb_down, pb_up and pb_long to 0.
REQ-023 SHALL discard any in-progress count on reset; after release, a PB held pressed SHALL produce pb_down exactly SYNC_STAGES + STABLE_CYCLES edges later.

Structure
REQ-024 SHALL place default parameter constants and the counter-width function in shared package pb_debounce_pkg.
REQ-025 SHALL implement one channel in sub-module pb_debounce_ch, instantiated N_CH times in a generate loop.

Verification (20 ns clock, STABLE_CYCLES=20, SYNC_STAGES=2, LONG_CYCLES=100, N_CH=4)
REQ-026 SHALL cover: PB[0] 0->1 clean, held 200 cycles -> pb_down[0] single pulse 22 edges after the step, PB_state[0]=1 from that edge.
REQ-027 SHALL cover: PB[1] toggling every 5 cycles for 40 cycles then stable 1 -> no pulses during bounce; single pb_down[1] 22 edges after the last toggle.
REQ-028 SHALL cover: PB[2] high for exactly 19 cycles then low -> PB_state[2] stays 0, no pulses.
REQ-029 SHALL cover: PB[0] held pressed -> pb_long[0] single pulse 100 cycles after PB_state[0] rise; release -> pb_up[0] 22 edges later, no further pb_long.
REQ-030 SHALL cover: reset asserted 10 cycles into a press count, PB held 1 -> all outputs 0 during reset; pb_down 22 edges after reset deasserts.
REQ-031 SHALL cover: PB[0] and PB[3] pressed in the same cycle with ACTIVE_LOW=1 (drive 1->0) -> pb_down[0] and pb_down[3] pulse in the same cycle.

Source files
------------

// File: rtl/pb_debounce_pkg.sv
// Shared defaults and sizing helper for the push-button debouncer array.
package pb_debounce_pkg;

  localparam int DEF_N_CH          = 4;
  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_LONG_CYCLES   = 0;
  localparam int DEF_ACTIVE_LOW    = 0;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One push-button channel: synchroniser, stability counter, edge pulses and
// optional long-press detection.
module pb_debounce_ch
  import pb_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic state,
  output logic pb_down,
  output logic pb_up,
  output logic pb_long
);

  localparam int STB_W = cnt_width(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [STB_W-1:0]       stable_cnt;
  logic                   accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = sync[SYNC_STAGES-1];

  // The level is accepted on the STABLE_CYCLES-th consecutive mismatch cycle.
  assign accept = (synced != state) && (stable_cnt == STB_W'(STABLE_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_cnt <= '0;
      state      <= 1'b0;
      pb_down    <= 1'b0;
      pb_up      <= 1'b0;
    end else begin
      pb_down <= 1'b0;
      pb_up   <= 1'b0;
      if (synced == state) begin
        stable_cnt <= '0;
      end else if (accept) begin
        stable_cnt <= '0;
        state      <= synced;
        pb_down    <= synced;
        pb_up      <= ~synced;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  generate
    if (LONG_CYCLES > 0) begin : g_long
      localparam int LONG_W = cnt_width(LONG_CYCLES + 1);
      logic [LONG_W-1:0] long_cnt;

      // Counter saturates at LONG_CYCLES so the pulse fires once per press.
      always_ff @(posedge clock) begin
        if (reset) begin
          long_cnt <= '0;
          pb_long  <= 1'b0;
        end else begin
          pb_long <= 1'b0;
          if (!state) begin
            long_cnt <= '0;
          end else if (long_cnt != LONG_W'(LONG_CYCLES)) begin
            long_cnt <= long_cnt + 1'b1;
            pb_long  <= (long_cnt == LONG_W'(LONG_CYCLES - 1));
          end
        end
      end
    end else begin : g_no_long
      assign pb_long = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pb_debouncer_array.sv
// Array of independent push-button debouncers sharing one clock and reset.
module pb_debouncer_array
  import pb_debounce_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] PB,
  output logic [N_CH-1:0] PB_state,
  output logic [N_CH-1:0] pb_down,
  output logic [N_CH-1:0] pb_up,
  output logic [N_CH-1:0] pb_long
);

  logic [N_CH-1:0] raw;

  // Inversion happens before synchronisation so the channels only see 1 = pressed.
  assign raw = (ACTIVE_LOW != 0) ? ~PB : PB;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pb_debounce_ch #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES),
        .LONG_CYCLES   (LONG_CYCLES)
      ) u_ch (
        .clock   (clock),
        .reset   (reset),
        .raw     (raw[i]),
        .state   (PB_state[i]),
        .pb_down (pb_down[i]),
        .pb_up   (pb_up[i]),
        .pb_long (pb_long[i])
      );
    end
  endgenerate

endmodule
